// File: rtl/imm_decode_stage.sv
// Registered multi-lane RV32/RV64 immediate decode stage with a valid/ready handshake and a saturating illegal counter.
// Optional compressed decode is enabled by defining IMM_DECODE_RVC_EN.

module imm_decode_lane #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic            vld,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      typ,
    output logic            ill
);
    localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                           T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6;

    logic [31:0] i32;

    always_comb begin
        i32 = '0;
        typ = T_NONE;
        ill = 1'b0;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:2])
                5'b00000, 5'b00001, 5'b00100, 5'b11001: begin
                    typ = T_I;
                    i32 = {{20{inst[31]}}, inst[31:20]};
                end
                5'b01000, 5'b01001: begin
                    typ = T_S;
                    i32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                end
                5'b11000: begin
                    typ = T_B;
                    i32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                5'b01101, 5'b00101: begin
                    typ = T_U;
                    i32 = {inst[31:12], 12'b0};
                end
                5'b11011: begin
                    typ = T_J;
                    i32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                5'b11100: begin
                    if (inst[14]) begin
                        typ = T_Z;
                        i32 = {27'b0, inst[19:15]};
                    end
                end
                5'b01100, 5'b10100, 5'b00011: ;
                default: ill = 1'b1;
            endcase
        end else begin
`ifdef IMM_DECODE_RVC_EN
            // key is {quadrant, funct3} of the 16-bit parcel
            case ({inst[1:0], inst[15:13]})
                5'b01_000, 5'b01_010: begin
                    typ = T_I;
                    i32 = {{26{inst[12]}}, inst[12], inst[6:2]};
                end
                5'b01_011: begin
                    if (inst[11:7] != 5'd0 && inst[11:7] != 5'd2) begin
                        typ = T_U;
                        i32 = {{14{inst[12]}}, inst[12], inst[6:2], 12'b0};
                    end else begin
                        ill = 1'b1;
                    end
                end
                5'b01_101: begin
                    typ = T_J;
                    i32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                           inst[2], inst[11], inst[5:3], 1'b0};
                end
                5'b01_110, 5'b01_111: begin
                    typ = T_B;
                    i32 = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
                end
                5'b00_010: begin
                    typ = T_I;
                    i32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b0};
                end
                5'b00_110: begin
                    typ = T_S;
                    i32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b0};
                end
                default: ill = 1'b1;
            endcase
`else
            ill = 1'b1;
`endif
        end
        if (!vld) begin
            i32 = '0;
            typ = T_NONE;
            ill = 1'b0;
        end
    end

    if (XLEN == 64) begin : g_x64
        assign imm = {{32{i32[31]}}, i32};
    end else begin : g_x32
        assign imm = i32;
    end
endmodule

module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int LANES = 1,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_vld,
    input  logic [32*LANES-1:0]   in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_vld,
    output logic [XLEN*LANES-1:0] out_imm,
    output logic [3*LANES-1:0]    out_type,
    output logic [LANES-1:0]      out_illegal,
    output logic [CNT_W-1:0]      illegal_cnt
);
    logic [LANES-1:0][31:0]     inst_l;
    logic [LANES-1:0][XLEN-1:0] imm_d, imm_q;
    logic [LANES-1:0][2:0]      typ_d, typ_q;
    logic [LANES-1:0]           ill_d, ill_q, lvld_q;
    logic                       vld_q, accept;
    logic [2:0]                 nill;
    logic [CNT_W+2:0]           cnt_sum;
    logic [CNT_W-1:0]           cnt_q;

    assign inst_l = in_inst;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        imm_decode_lane #(.XLEN(XLEN)) u_lane (
            .inst (inst_l[g]),
            .vld  (in_lane_vld[g]),
            .imm  (imm_d[g]),
            .typ  (typ_d[g]),
            .ill  (ill_d[g])
        );
    end

    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        nill = '0;
        for (int k = 0; k < LANES; k++) nill = nill + {2'b0, ill_d[k]};
    end

    // widened by 3 bits so the add cannot wrap before the saturation compare
    assign cnt_sum = {3'b0, cnt_q} + {{CNT_W{1'b0}}, nill};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            lvld_q <= '0;
            imm_q  <= '0;
            typ_q  <= '0;
            ill_q  <= '0;
        end else if (flush) begin
            vld_q  <= 1'b0;
            lvld_q <= '0;
        end else if (accept) begin
            vld_q  <= 1'b1;
            lvld_q <= in_lane_vld;
            imm_q  <= imm_d;
            typ_q  <= typ_d;
            ill_q  <= ill_d;
        end else if (out_ready) begin
            vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= (cnt_sum > {3'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    assign out_valid    = vld_q;
    assign out_lane_vld = lvld_q;
    assign out_imm      = imm_q;
    assign out_type     = typ_q;
    assign out_illegal  = ill_q;
    assign illegal_cnt  = cnt_q;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: three configurations (32b/2 lanes, 64b/1 lane, 2-bit counter).
module tb_imm_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // DUT a: XLEN=32, LANES=2, CNT_W=16
    logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
    logic [1:0]  a_in_lane_vld = 0, a_out_lane_vld, a_out_illegal;
    logic [63:0] a_in_inst = 0, a_out_imm;
    logic [5:0]  a_out_type;
    logic [15:0] a_cnt;
    // DUT b: XLEN=64, LANES=1
    logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
    logic        b_in_lane_vld = 0, b_out_lane_vld, b_out_illegal;
    logic [31:0] b_in_inst = 0;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_type;
    logic [15:0] b_cnt;
    // DUT c: XLEN=32, LANES=2, CNT_W=2
    logic        c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 1;
    logic [1:0]  c_in_lane_vld = 0, c_out_lane_vld, c_out_illegal;
    logic [63:0] c_in_inst = 0, c_out_imm;
    logic [5:0]  c_out_type;
    logic [1:0]  c_cnt;

    imm_decode_stage #(.XLEN(32), .LANES(2), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_lane_vld(a_in_lane_vld), .in_inst(a_in_inst), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_lane_vld(a_out_lane_vld), .out_imm(a_out_imm),
        .out_type(a_out_type), .out_illegal(a_out_illegal), .illegal_cnt(a_cnt));
    imm_decode_stage #(.XLEN(64), .LANES(1), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_lane_vld(b_in_lane_vld), .in_inst(b_in_inst), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_lane_vld(b_out_lane_vld), .out_imm(b_out_imm),
        .out_type(b_out_type), .out_illegal(b_out_illegal), .illegal_cnt(b_cnt));
    imm_decode_stage #(.XLEN(32), .LANES(2), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_lane_vld(c_in_lane_vld), .in_inst(c_in_inst), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_lane_vld(c_out_lane_vld), .out_imm(c_out_imm),
        .out_type(c_out_type), .out_illegal(c_out_illegal), .illegal_cnt(c_cnt));

    int exp_cnt = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] lv);
        a_in_inst = {i1, i0};
        a_in_lane_vld = lv;
        a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_lane_vld !== 2'b0 || a_out_imm !== 64'h0 ||
            a_out_type !== 6'h0 || a_out_illegal !== 2'b0 || a_cnt !== 16'h0) begin
            $display("FAIL reset_a: valid=%b lvld=%b imm=%h type=%h ill=%b cnt=%0d, expected all zero",
                     a_out_valid, a_out_lane_vld, a_out_imm, a_out_type, a_out_illegal, a_cnt);
            failures++;
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_imm !== 64'h0 || c_out_valid !== 1'b0 || c_cnt !== 2'd0) begin
            $display("FAIL reset_bc: b_valid=%b b_imm=%h c_valid=%b c_cnt=%0d, expected zero",
                     b_out_valid, b_out_imm, c_out_valid, c_cnt);
            failures++;
        end
        #10 rst_n = 1'b1;
        tick();
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: a=%b b=%b c=%b, expected 1", a_in_ready, b_in_ready, c_in_ready);
            failures++;
        end
    endtask

    task automatic test_decode;
        logic [31:0] tin  [9] = '{32'hFFF00093, 32'hFE000EE3, 32'hFE112C23, 32'hFF9FF0EF, 32'h300AD073,
                                  32'h00000073, 32'h00208133, 32'h12345097, 32'h0000007F};
        logic [31:0] eimm [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h00000015,
                                  32'h0, 32'h0, 32'h12345000, 32'h0};
        logic [2:0]  etyp [9] = '{3'd1, 3'd3, 3'd2, 3'd5, 3'd6, 3'd0, 3'd0, 3'd4, 3'd0};
        logic        eill [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int k = 0; k < 9; k++) begin
            int j;
            j = (k + 3) % 9;
            a_send(tin[k], tin[j], 2'b11);
            exp_cnt += int'(eill[k]) + int'(eill[j]);
            checks++;
            if (a_out_valid !== 1'b1 || a_out_lane_vld !== 2'b11 || a_out_imm[31:0] !== eimm[k] ||
                a_out_type[2:0] !== etyp[k] || a_out_illegal[0] !== eill[k]) begin
                $display("FAIL decode_l0 inst=%h: valid=%b lvld=%b imm=%h type=%0d ill=%b, expected 1 11 %h %0d %b",
                         tin[k], a_out_valid, a_out_lane_vld, a_out_imm[31:0], a_out_type[2:0],
                         a_out_illegal[0], eimm[k], etyp[k], eill[k]);
                failures++;
            end
            checks++;
            if (a_out_imm[63:32] !== eimm[j] || a_out_type[5:3] !== etyp[j] || a_out_illegal[1] !== eill[j]) begin
                $display("FAIL decode_l1 inst=%h: imm=%h type=%0d ill=%b, expected %h %0d %b",
                         tin[j], a_out_imm[63:32], a_out_type[5:3], a_out_illegal[1], eimm[j], etyp[j], eill[j]);
                failures++;
            end
        end
        checks++;
        if (a_cnt !== 16'(exp_cnt)) begin
            $display("FAIL decode_cnt: cnt=%0d, expected %0d", a_cnt, exp_cnt);
            failures++;
        end
    endtask

    task automatic test_lane_mask;
        a_send(32'hFFF00093, 32'h0000007F, 2'b01);
        checks++;
        if (a_out_lane_vld !== 2'b01 || a_out_imm[63:32] !== 32'h0 || a_out_type[5:3] !== 3'd0 ||
            a_out_illegal[1] !== 1'b0 || a_cnt !== 16'(exp_cnt)) begin
            $display("FAIL lane_mask: lvld=%b imm1=%h type1=%0d ill1=%b cnt=%0d, expected 01 0 0 0 %0d",
                     a_out_lane_vld, a_out_imm[63:32], a_out_type[5:3], a_out_illegal[1], a_cnt, exp_cnt);
            failures++;
        end
    endtask

    task automatic test_rvc;
        logic [31:0] eimm;
        logic [2:0]  etyp;
        logic        eill;
`ifdef IMM_DECODE_RVC_EN
        eimm = 32'hFFFFFFFF; etyp = 3'd1; eill = 1'b0;
`else
        eimm = 32'h0; etyp = 3'd0; eill = 1'b1;
`endif
        a_send(32'h000050FD, 32'h0, 2'b01);
        exp_cnt += int'(eill);
        checks++;
        if (a_out_imm[31:0] !== eimm || a_out_type[2:0] !== etyp || a_out_illegal[0] !== eill ||
            a_cnt !== 16'(exp_cnt)) begin
            $display("FAIL rvc_c_li: imm=%h type=%0d ill=%b cnt=%0d, expected %h %0d %b %0d",
                     a_out_imm[31:0], a_out_type[2:0], a_out_illegal[0], a_cnt, eimm, etyp, eill, exp_cnt);
            failures++;
        end
    endtask

    task automatic test_backpressure;
        a_send(32'hFFF00093, 32'h0, 2'b01);
        a_out_ready = 1'b0;
        a_in_inst = {32'h0, 32'h12345097};
        a_in_lane_vld = 2'b01;
        a_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_imm[31:0] !== 32'hFFFFFFFF ||
                a_out_type[2:0] !== 3'd1) begin
                $display("FAIL stall_hold cyc=%0d: in_ready=%b valid=%b imm=%h type=%0d, expected 0 1 ffffffff 1",
                         k, a_in_ready, a_out_valid, a_out_imm[31:0], a_out_type[2:0]);
                failures++;
            end
        end
        a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            $display("FAIL stall_release_ready: in_ready=%b, expected 1", a_in_ready);
            failures++;
        end
        tick();
        a_in_inst = {32'h0, 32'hFE000EE3};
        checks++;
        if (a_out_valid !== 1'b1 || a_out_imm[31:0] !== 32'h12345000 || a_out_type[2:0] !== 3'd4) begin
            $display("FAIL stall_next: valid=%b imm=%h type=%0d, expected 1 12345000 4",
                     a_out_valid, a_out_imm[31:0], a_out_type[2:0]);
            failures++;
        end
        tick();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_imm[31:0] !== 32'hFFFFFFFC || a_out_type[2:0] !== 3'd3) begin
            $display("FAIL back_to_back: valid=%b imm=%h type=%0d, expected 1 fffffffc 3",
                     a_out_valid, a_out_imm[31:0], a_out_type[2:0]);
            failures++;
        end
        tick();
        checks++;
        if (a_out_valid !== 1'b0) begin
            $display("FAIL drain: valid=%b, expected 0", a_out_valid);
            failures++;
        end
    endtask

    task automatic test_flush;
        a_send(32'hFFF00093, 32'hFFF00093, 2'b11);
        a_in_inst = {32'h0000007F, 32'h0000007F};
        a_in_lane_vld = 2'b11;
        a_in_valid = 1'b1;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_lane_vld !== 2'b00 || a_cnt !== 16'(exp_cnt)) begin
            $display("FAIL flush: valid=%b lvld=%b cnt=%0d, expected 0 00 %0d",
                     a_out_valid, a_out_lane_vld, a_cnt, exp_cnt);
            failures++;
        end
    endtask

    task automatic test_count;
        for (int k = 0; k < 3; k++) a_send(32'h0000007F, 32'h0000007F, 2'b11);
        exp_cnt += 6;
        checks++;
        if (a_cnt !== 16'(exp_cnt) || a_out_illegal !== 2'b11) begin
            $display("FAIL count_6: cnt=%0d ill=%b, expected %0d 11", a_cnt, a_out_illegal, exp_cnt);
            failures++;
        end
    endtask

    task automatic test_saturate;
        logic [1:0] ecnt [3] = '{2'd2, 2'd3, 2'd3};
        c_in_inst = {32'h0000007F, 32'h0000007F};
        c_in_lane_vld = 2'b11;
        for (int k = 0; k < 3; k++) begin
            c_in_valid = 1'b1;
            tick();
            c_in_valid = 1'b0;
            checks++;
            if (c_cnt !== ecnt[k] || c_out_valid !== 1'b1 || c_out_lane_vld !== 2'b11 ||
                c_out_illegal !== 2'b11 || c_out_imm !== 64'h0 || c_out_type !== 6'h0) begin
                $display("FAIL saturate grp=%0d: cnt=%0d valid=%b lvld=%b ill=%b imm=%h type=%h, expected %0d 1 11 11 0 0",
                         k, c_cnt, c_out_valid, c_out_lane_vld, c_out_illegal, c_out_imm, c_out_type, ecnt[k]);
                failures++;
            end
        end
    endtask

    task automatic test_xlen64;
        logic [31:0] tin  [2] = '{32'h800000B7, 32'hFFF00093};
        logic [63:0] eimm [2] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF};
        logic [2:0]  etyp [2] = '{3'd4, 3'd1};
        for (int k = 0; k < 2; k++) begin
            b_in_inst = tin[k];
            b_in_lane_vld = 1'b1;
            b_in_valid = 1'b1;
            tick();
            b_in_valid = 1'b0;
            checks++;
            if (b_out_valid !== 1'b1 || b_out_lane_vld !== 1'b1 || b_out_imm !== eimm[k] ||
                b_out_type !== etyp[k] || b_out_illegal !== 1'b0 || b_cnt !== 16'h0) begin
                $display("FAIL xlen64 inst=%h: valid=%b lvld=%b imm=%h type=%0d ill=%b cnt=%0d, expected 1 1 %h %0d 0 0",
                         tin[k], b_out_valid, b_out_lane_vld, b_out_imm, b_out_type, b_out_illegal, b_cnt,
                         eimm[k], etyp[k]);
                failures++;
            end
        end
    endtask

    task automatic test_async_reset;
        a_send(32'h0000007F, 32'hFFF00093, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_lane_vld !== 2'b0 || a_out_imm !== 64'h0 ||
            a_out_illegal !== 2'b0 || a_cnt !== 16'h0 || c_cnt !== 2'd0) begin
            $display("FAIL async_reset: valid=%b lvld=%b imm=%h ill=%b cnt=%0d c_cnt=%0d, expected all zero",
                     a_out_valid, a_out_lane_vld, a_out_imm, a_out_illegal, a_cnt, c_cnt);
            failures++;
        end
        #5 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_lane_mask();
        test_rvc();
        test_backpressure();
        test_flush();
        test_count();
        test_saturate();
        test_xlen64();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
